fb_scanout_reader: RTL and testbench
====================================

Name: fb_scanout_reader

Overview:
Downstream consumer of the 512x8 pseudo-dual-port frame-buffer RAM in the display frame buffer path. On a start pulse it reads FRAME_BYTES consecutive bytes from the RAM read port, beginning at a latched base address. It absorbs the RAM's one-cycle registered read latency and delivers the bytes in order on a valid/ready stream to the display serializer. A 4-entry output FIFO lets it sustain one byte per clock under continuous ready.

Parameters:
ADDR_WIDTH, 9, RAM address width; read addresses wrap modulo 2^ADDR_WIDTH.
DATA_WIDTH, 8, RAM and pixel data width.
FRAME_BYTES, 512, bytes per frame; legal range 1..2^ADDR_WIDTH.

Ports:
clk  input  1  single clock; also drives the RAM rclk.
rst  input  1  synchronous reset, active-high.
start  input  1  one-cycle request to begin a frame; ignored while busy=1.
base_addr  input  ADDR_WIDTH  first RAM address; sampled only on an accepted start.
abort  input  1  synchronous cancel of the current frame.
read_en  output  1  RAM read enable (connects to RE).
raddr  output  ADDR_WIDTH  RAM read address.
rdata  input  DATA_WIDTH  RAM dout; valid the cycle after read_en=1.
pix_data  output  DATA_WIDTH  head of the output FIFO.
pix_valid  output  1  output FIFO is non-empty.
pix_ready  input  1  downstream accepts the byte when pix_valid & pix_ready.
busy  output  1  frame in progress.
frame_done  output  1  one-cycle pulse when the last byte has been accepted.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; FIFO empty; in-flight count=0; issue and accept counters=0. Outputs: read_en=0, raddr=0, pix_valid=0, pix_data=0, busy=0, frame_done=0. Reset overrides every other input, including mid-frame.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN when start=1. On that edge: latch base_addr, busy=1, clear counters.
  - RUN -> DRAIN when the issue counter reaches FRAME_BYTES (all reads issued).
  - DRAIN -> IDLE when the accept counter reaches FRAME_BYTES. On that edge: frame_done=1 for exactly one cycle, busy=0 in the same cycle.
- Read issue:
  - read_en=1 only in RUN, and only when issued < FRAME_BYTES and fifo_count + inflight < 4.
  - raddr = (latched_base + issued) mod 2^ADDR_WIDTH. Address 2^ADDR_WIDTH-1 wraps to 0.
  - Issuing does not look ahead at pops in the same cycle.
- Capture:
  - Data from a read issued in cycle N appears on rdata in cycle N+1 and is written into the FIFO at the end of N+1.
  - inflight is at most 1.
- Output:
  - pix_valid=1 whenever the FIFO is non-empty. pix_data holds stable while pix_valid=1 and pix_ready=0.
  - A pop occurs on pix_valid & pix_ready. Push and pop in the same cycle are both honoured.
- Latency: start sampled at edge 0 gives read_en=1 in cycle 1, with data captured at the end of cycle 2 and pix_valid=1 in cycle 3. With pix_ready held at 1, one byte is delivered per cycle with no bubbles.
- Overflow: cannot occur by construction (credit rule). An assertion in the bench checks that fifo_count never exceeds 4.
- abort=1 (any non-IDLE state):
  - Next edge: state=IDLE, FIFO flushed, busy=0, read_en=0, no frame_done.
  - Read data still in flight is discarded.
  - abort in IDLE has no effect. If abort and start are both 1 in IDLE, start wins.
- start while busy=1: ignored; base_addr is not resampled.
- FRAME_BYTES=1: exactly one read and one pix_valid beat, followed by frame_done.

Test Plan:
- Basic frame: preload RAM[i]=i[7:0], base=0, pix_ready=1, start -> 512 bytes 0x00..0xFF,0x00..0xFF on consecutive cycles; first pix_valid 3 cycles after start; frame_done once; busy low afterwards.
- Wrap-around: base=0x1F0, RAM[i]=i[7:0] -> first byte 0xF0; after 16 bytes raddr goes 0x1FF->0x000 and the byte sequence continues ...,0xFF,0x00; 512 bytes total.
- Backpressure: pix_ready toggled randomly (~50%) -> pix_data stable while stalled; byte sequence identical to the basic frame; read_en never fires when fifo_count + inflight = 4.
- Abort mid-frame: abort asserted after 100 accepted bytes -> next cycle busy=0, pix_valid=0, no frame_done; a new start then delivers the full frame from the new base.
- Reset mid-frame: rst=1 for one cycle during DRAIN -> all outputs at reset values the next cycle; start then behaves exactly as after power-up.
- Ignored start: second start with base=0x100 pulsed during busy -> current frame unaffected; only one frame_done is produced.

Source files
------------

// File: rtl/fb_scanout_reader.sv
// fb_scanout_reader: streams FRAME_BYTES consecutive bytes from the frame-buffer
// RAM read port, starting at a latched base address, onto a valid/ready pixel
// stream. A 4-entry FIFO absorbs the RAM's one-cycle read latency. Reads are
// issued only when the FIFO is guaranteed to have room for the returning byte.
module fb_scanout_reader #(
   parameter int ADDR_WIDTH  = 9,
   parameter int DATA_WIDTH  = 8,
   parameter int FRAME_BYTES = 512
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic                  abort,
   output logic                  read_en,
   output logic [ADDR_WIDTH-1:0] raddr,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [DATA_WIDTH-1:0] pix_data,
   output logic                  pix_valid,
   input  logic                  pix_ready,
   output logic                  busy,
   output logic                  frame_done
);

   // Counters need one extra bit so a full 2^ADDR_WIDTH frame is representable.
   localparam int CNT_W = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BYTES);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [CNT_W-1:0]      issued_q, issued_d;
   logic [CNT_W-1:0]      accepted_q, accepted_d;
   logic                  inflight_q, inflight_d;
   logic [DATA_WIDTH-1:0] mem_q [4];
   logic [DATA_WIDTH-1:0] mem_d [4];
   logic [1:0]            wr_ptr_q, wr_ptr_d;
   logic [1:0]            rd_ptr_q, rd_ptr_d;
   logic [2:0]            count_q, count_d;
   logic                  frame_done_q, frame_done_d;
   logic                  issue, push, pop;

   // Handshake terms: credit-gated issue, capture of last cycle's read, and pop.
   always_comb begin
      issue = (state_q == S_RUN) && (issued_q < FRAME_CNT) &&
              (({1'b0, count_q} + {3'b000, inflight_q}) < 4'd4);
      push  = inflight_q;
      pop   = (count_q != 3'd0) && pix_ready;
   end

   // Next-state for the frame controller, counters and FIFO.
   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      issued_d     = issued_q;
      accepted_d   = accepted_q;
      inflight_d   = issue;
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q + {2'b00, push} - {2'b00, pop};
      frame_done_d = 1'b0;

      if (push) begin
         mem_d[wr_ptr_q] = rdata;
         wr_ptr_d        = wr_ptr_q + 2'd1;
      end
      if (pop) begin
         rd_ptr_d   = rd_ptr_q + 2'd1;
         accepted_d = accepted_q + 1'b1;
      end
      if (issue) begin
         issued_d = issued_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_RUN;
               base_d     = base_addr;
               issued_d   = '0;
               accepted_d = '0;
            end
         end
         S_RUN: begin
            if (!abort && issued_d == FRAME_CNT) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!abort && pop && accepted_d == FRAME_CNT) begin
               state_d      = S_IDLE;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Cancel: drop buffered and in-flight bytes, no completion pulse.
      if (abort && state_q != S_IDLE) begin
         state_d      = S_IDLE;
         inflight_d   = 1'b0;
         wr_ptr_d     = 2'd0;
         rd_ptr_d     = 2'd0;
         count_d      = 3'd0;
         frame_done_d = 1'b0;
      end
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         base_q       <= '0;
         issued_q     <= '0;
         accepted_q   <= '0;
         inflight_q   <= 1'b0;
         wr_ptr_q     <= 2'd0;
         rd_ptr_q     <= 2'd0;
         count_q      <= 3'd0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         issued_q     <= issued_d;
         accepted_q   <= accepted_d;
         inflight_q   <= inflight_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         frame_done_q <= frame_done_d;
      end
   end

   // FIFO storage; contents are only meaningful under count_q, so no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Output mapping; pix_data is forced to zero when the FIFO is empty.
   always_comb begin
      read_en    = issue;
      raddr      = base_q + issued_q[ADDR_WIDTH-1:0];
      pix_valid  = (count_q != 3'd0);
      pix_data   = pix_valid ? mem_q[rd_ptr_q] : '0;
      busy       = (state_q != S_IDLE);
      frame_done = frame_done_q;
   end

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Testbench for fb_scanout_reader: RAM model, randomized backpressure,
// queue-based scoreboard with an independent monitor process.
module tb_fb_scanout_reader;

   localparam int AW = 9;
   localparam int DW = 8;
   localparam int FB = 512;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic          abort = 1'b0;
   logic          read_en;
   logic [AW-1:0] raddr;
   logic [DW-1:0] rdata = '0;
   logic [DW-1:0] pix_data;
   logic          pix_valid;
   logic          pix_ready = 1'b0;
   logic          busy;
   logic          frame_done;

   fb_scanout_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_BYTES(FB)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .abort(abort),
      .read_en(read_en), .raddr(raddr), .rdata(rdata), .pix_data(pix_data),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      bit            last;
   } exp_t;

   logic [DW-1:0] ram [1 << AW];
   exp_t          sb [$];
   int            compared = 0;
   int            mismatched = 0;
   int            outstanding = 0;
   int            rd_cnt = 0;
   int            pop_cnt = 0;
   int            done_cnt = 0;
   bit            exp_done_next = 0;
   bit            stall_prev = 0;
   logic [DW-1:0] stall_data = '0;
   int            ready_mode = 0;   // 0: always ready, 1: random, 2: held low

   // Registered-read RAM model.
   always @(posedge clk) begin
      if (read_en) rdata <= ram[raddr];
   end

   // Downstream ready driver.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = 1'($urandom_range(0, 1));
            default: pix_ready = 1'b0;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on each accepted beat and checks protocol rules.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         chk("frame_done", {31'b0, frame_done}, {31'b0, exp_done_next});
         if (frame_done) begin
            chk("busy_at_done", {31'b0, busy}, 32'd0);
            done_cnt++;
         end
         exp_done_next = 0;
         if (stall_prev) begin
            chk("stall_valid", {31'b0, pix_valid}, 32'd1);
            chk("stall_data", {24'b0, pix_data}, {24'b0, stall_data});
         end
         if (read_en) begin
            chk("credit", 32'(outstanding), 32'(outstanding < 4 ? outstanding : 3));
            rd_cnt++;
         end
         if (pix_valid && pix_ready) begin
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_beat: got 0x%0h expected no beat at %0t", pix_data, $time);
            end else begin
               e = sb.pop_front();
               chk("pix_data", {24'b0, pix_data}, {24'b0, e.d});
               if (e.last) exp_done_next = 1;
               pop_cnt++;
            end
         end
         outstanding = outstanding + int'(read_en) - int'(pix_valid && pix_ready);
         stall_prev  = pix_valid && !pix_ready;
         stall_data  = pix_data;
      end
   end

   task automatic clear_model();
      sb.delete();
      outstanding   = 0;
      stall_prev    = 0;
      exp_done_next = 0;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_read_en"},    {31'b0, read_en},    32'd0);
      chk({tag, "_raddr"},      {23'b0, raddr},      32'd0);
      chk({tag, "_pix_valid"},  {31'b0, pix_valid},  32'd0);
      chk({tag, "_pix_data"},   {24'b0, pix_data},   32'd0);
      chk({tag, "_busy"},       {31'b0, busy},       32'd0);
      chk({tag, "_frame_done"}, {31'b0, frame_done}, 32'd0);
   endtask

   // Issue a start; the expected frame is pushed when the start is accepted.
   task automatic start_frame(input logic [AW-1:0] b, input bit lat_chk);
      exp_t e;
      @(posedge clk);
      #2;
      start     = 1'b1;
      base_addr = b;
      for (int i = 0; i < FB; i++) begin
         e.d    = ram[(int'(b) + i) % (1 << AW)];
         e.last = (i == FB - 1);
         sb.push_back(e);
      end
      rd_cnt  = 0;
      pop_cnt = 0;
      @(posedge clk);
      #2;
      start     = 1'b0;
      base_addr = AW'($urandom);
      if (lat_chk) begin
         @(negedge clk);
         chk("lat_c1_read_en", {31'b0, read_en}, 32'd1);
         chk("lat_c1_raddr", {23'b0, raddr}, {23'b0, b});
         chk("lat_c1_valid", {31'b0, pix_valid}, 32'd0);
         @(negedge clk);
         chk("lat_c2_valid", {31'b0, pix_valid}, 32'd0);
         @(negedge clk);
         chk("lat_c3_valid", {31'b0, pix_valid}, 32'd1);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((busy || sb.size() != 0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         compared++;
         mismatched++;
         $display("FAIL %s_timeout: busy=%0d left=%0d expected idle", tag, busy, sb.size());
      end
      @(negedge clk);
      chk({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
   endtask

   task automatic run_frame(input string tag, input logic [AW-1:0] b, input bit lat_chk);
      int d0;
      d0 = done_cnt;
      start_frame(b, lat_chk);
      wait_idle(tag);
      chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
      chk({tag, "_beats"}, 32'(pop_cnt), 32'(FB));
   endtask

   initial begin
      int d0;
      int n;
      #10000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int n;
      for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);

      // Power-up reset.
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      chk_reset_outs("por");

      // Basic frame with latency check, then wrap-around frame.
      ready_mode = 0;
      run_frame("basic", 9'h000, 1);
      run_frame("wrap", 9'h1F0, 1);

      // Random contents and random backpressure.
      for (int i = 0; i < (1 << AW); i++) ram[i] = DW'($urandom);
      ready_mode = 1;
      run_frame("bp", 9'h000, 0);
      run_frame("bp_rand", AW'($urandom), 0);

      // Abort after 100 accepted beats, then restart from a new base.
      d0 = done_cnt;
      start_frame(AW'($urandom), 0);
      n = 0;
      while (pop_cnt < 100 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reached_100", 32'(pop_cnt >= 100), 32'd1);
      ready_mode = 2;
      @(posedge clk);
      #2;
      abort = 1'b1;
      @(posedge clk);
      #2;
      abort = 1'b0;
      clear_model();
      @(negedge clk);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_valid", {31'b0, pix_valid}, 32'd0);
      repeat (3) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      ready_mode = 1;
      run_frame("after_abort", AW'($urandom), 0);

      // Reset while draining, then a power-up-like frame.
      start_frame(AW'($urandom), 0);
      n = 0;
      while (rd_cnt < FB && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_reached", 32'(rd_cnt), 32'(FB));
      ready_mode = 2;
      @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      clear_model();
      @(negedge clk);
      chk_reset_outs("mid_rst");
      ready_mode = 0;
      run_frame("after_rst", 9'h000, 1);

      // A start during a busy frame is ignored.
      ready_mode = 1;
      d0 = done_cnt;
      start_frame(AW'($urandom), 0);
      repeat (40) @(posedge clk);
      #2;
      start     = 1'b1;
      base_addr = 9'h100;
      @(posedge clk);
      #2;
      start = 1'b0;
      wait_idle("ignored_start");
      chk("ignored_start_done_cnt", 32'(done_cnt - d0), 32'd1);
      repeat (5) @(negedge clk);
      chk("ignored_start_stays_idle", {31'b0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
